serial_shift_unit: RTL and testbench

- Multi-cycle shifter in the EX stage. It consumes the 32-bit shift-amount operand produced by the shift-operand select (either the zero-extended instruction shamt or the register value for variable shifts), together with the data operand.
- It shifts by up to STEP_BITS positions per cycle and raises Done when the result is ready.
- Busy drives the pipeline stall.
- It replaces the single-cycle barrel-shift path, which reduces area and critical path.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_step.sv | 39 +++
 rtl/serial_shift_unit.sv | 97 +++++++++
 tb/tb_serial_shift_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serial shifter: op codes, FSM states, widths.
// Pure declarations, no logic and no latency.
// Imported by the step shifter and the serial_shift_unit top.
package shift_pkg;

  localparam int WIDTH_C  = 32;
  localparam int AMT_BITS = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Single-step shifter: shifts data_i by k_i positions for the given op.
// Purely combinational, zero cycles; no handshake.
// ROTR is only built with SHIFT_ROTATE_EN; otherwise op 11 acts as SRL.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]    data_i,
  input  logic [AMT_BITS-1:0] k_i,
  input  shift_op_e           op_i,
  input  logic                fill_i,
  output logic [WIDTH-1:0]    data_o
);

  logic [WIDTH-1:0] srl_w;
  logic [WIDTH-1:0] sra_mask_w;

  assign srl_w      = data_i >> k_i;
  // Top k bits set: the positions vacated by a right shift.
  assign sra_mask_w = ~({WIDTH{1'b1}} >> k_i);

  // Select the shifted value; SRA fills with the latched sign, not data_i[31].
  always_comb begin
    data_o = srl_w;
    case (op_i)
      OP_SLL:  data_o = data_i << k_i;
      OP_SRL:  data_o = srl_w;
      OP_SRA:  data_o = fill_i ? (srl_w | sra_mask_w) : srl_w;
`ifdef SHIFT_ROTATE_EN
      OP_ROTR: data_o = srl_w | (data_i << (6'd32 - {1'b0, k_i}));
`else
      OP_ROTR: data_o = srl_w;
`endif
      default: data_o = srl_w;
    endcase
  end

endmodule

// File: rtl/serial_shift_unit.sv
// Multi-cycle EX-stage shifter, up to STEP_BITS positions per cycle.
// Latency: Done in the cycle after edge n + ceil(amt/STEP_BITS); amt=0 -> next cycle.
// Busy (stall) is high while shifting; Start is ignored then. Optional: SHIFT_ROTATE_EN.
module serial_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ShiftOp,
  input  logic [WIDTH-1:0] Data,
  input  logic [31:0]      Amount,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done
);

  localparam logic [AMT_BITS-1:0] STEP_K = AMT_BITS'(STEP_BITS);

  shift_state_e        state_q, state_d;
  logic [WIDTH-1:0]    work_q;
  logic [AMT_BITS-1:0] rem_q;
  shift_op_e           op_q;
  logic                sign_q;

  logic [AMT_BITS-1:0] k_w;
  logic [AMT_BITS-1:0] rem_next_w;
  logic [WIDTH-1:0]    step_w;
  logic                accept_w;
  logic                unused_amt;

  // Only the low five bits of the shift operand matter (Amount=32 acts as 0).
  assign unused_amt = ^Amount[31:AMT_BITS];

  assign accept_w   = (state_q != ST_SHIFT) && Start;
  assign k_w        = (rem_q < STEP_K) ? rem_q : STEP_K;
  assign rem_next_w = rem_q - k_w;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_i (work_q),
    .k_i    (k_w),
    .op_i   (op_q),
    .fill_i (sign_q),
    .data_o (step_w)
  );

  // State register; reset wins over everything, including Start.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: accept in IDLE/DONE, leave SHIFT once the count runs out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) state_d = (Amount[AMT_BITS-1:0] == '0) ? ST_DONE : ST_SHIFT;
        else       state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (rem_next_w == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decode directly from the state.
  always_comb begin
    Busy = (state_q == ST_SHIFT);
    Done = (state_q == ST_DONE);
  end

  // Datapath: load operands on accept, step while shifting, hold otherwise.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      work_q <= '0;
      rem_q  <= '0;
      op_q   <= OP_SLL;
      sign_q <= 1'b0;
    end else if (accept_w) begin
      work_q <= Data;
      rem_q  <= Amount[AMT_BITS-1:0];
      op_q   <= shift_op_e'(ShiftOp);
      sign_q <= Data[WIDTH-1];
    end else if (state_q == ST_SHIFT) begin
      work_q <= step_w;
      rem_q  <= rem_next_w;
    end
  end

  assign Result = work_q;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed + randomized bench for serial_shift_unit with a result scoreboard.
// Inputs change #1 after the rising edge; outputs are sampled there too.
// Define SHIFT_ROTATE_EN to match an RTL build with rotate enabled.
module tb_serial_shift_unit;

  localparam int STEP = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  ShiftOp;
  logic [31:0] Data;
  logic [31:0] Amount;
  logic [31:0] Result;
  logic        Busy;
  logic        Done;

  int passes = 0;
  int total  = 0;
  logic [31:0] sb_q[$];

  serial_shift_unit #(.WIDTH(32), .STEP_BITS(STEP)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .ShiftOp (ShiftOp),
    .Data    (Data),
    .Amount  (Amount),
    .Result  (Result),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                        input logic [31:0] a);
    int sh;
    logic [31:0] r;
    sh = int'(a[4:0]);
    case (op)
      2'b00: r = d << sh;
      2'b01: r = d >> sh;
      2'b10: r = $signed(d) >>> sh;
`ifdef SHIFT_ROTATE_EN
      default: r = (d >> sh) | (d << (32 - sh));
`else
      default: r = d >> sh;
`endif
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present a request for one edge and record its expected result.
  task automatic start_op(input logic [1:0] op, input logic [31:0] d,
                          input logic [31:0] a, input logic [31:0] exp);
    ShiftOp = op;
    Data    = d;
    Amount  = a;
    Start   = 1'b1;
    tick();
    Start   = 1'b0;
    sb_q.push_back(exp);
  endtask

  // Wait (bounded) for Done, checking latency, Busy duration and the result.
  task automatic wait_done(input string tag, input int exp_cyc);
    int cyc  = 0;
    int busy = 0;
    logic [31:0] exp;
    while (Done !== 1'b1 && cyc < 64) begin
      if (Busy === 1'b1) busy++;
      tick();
      cyc++;
    end
    check({tag, " done"}, {31'b0, Done}, 32'd1);
    check({tag, " latency"}, cyc, exp_cyc);
    check({tag, " busy"}, busy, exp_cyc);
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    else exp = 32'hDEAD_BEEF;
    check({tag, " result"}, Result, exp);
  endtask

  initial begin
    int dones;
    logic [1:0]  op;
    logic [31:0] d, a;

    Reset = 1'b1; Start = 1'b0; ShiftOp = 2'b00; Data = '0; Amount = '0;
    tick(); tick();
    check("reset result", Result, 32'h0);
    check("reset busy", {31'b0, Busy}, 32'd0);
    check("reset done", {31'b0, Done}, 32'd0);
    Reset = 1'b0;
    tick();

    // Longest shift: 31 positions in 8 steps.
    start_op(2'b00, 32'h0000_0001, 32'd31, 32'h8000_0000);
    wait_done("sll31", 8);
    tick();
    check("sll31 done one pulse", {31'b0, Done}, 32'd0);
    check("sll31 idle hold", Result, 32'h8000_0000);
    tick();
    check("sll31 idle hold2", Result, 32'h8000_0000);

    start_op(2'b10, 32'h8000_0000, 32'd4, 32'hF800_0000);
    wait_done("sra4", 1);
    tick();
    start_op(2'b01, 32'h8000_0000, 32'd4, 32'h0800_0000);
    wait_done("srl4", 1);
    tick();
    start_op(2'b10, 32'h8000_0000, 32'd9, 32'hFFC0_0000);
    wait_done("sra9", 3);
    tick();

    // Amount=32 has zero low bits: no shift, immediate Done.
    start_op(2'b00, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678);
    wait_done("amt32", 0);
    tick();

`ifdef SHIFT_ROTATE_EN
    start_op(2'b11, 32'h0000_000F, 32'd4, 32'hF000_0000);
`else
    start_op(2'b11, 32'h0000_000F, 32'd4, 32'h0000_0000);
`endif
    wait_done("op11", 1);
    tick();

    // Back-to-back: second Start lands in the DONE cycle.
    start_op(2'b01, 32'hF000_0000, 32'd8, 32'h00F0_0000);
    wait_done("b2b first", 2);
    start_op(2'b00, 32'h0000_0001, 32'd16, 32'h0001_0000);
    wait_done("b2b second", 4);
    tick();

    // Start while busy is ignored.
    start_op(2'b01, 32'hFFFF_0000, 32'd12, 32'h000F_FFF0);
    ShiftOp = 2'b00; Data = 32'hAAAA_AAAA; Amount = 32'd1; Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done("ignore start", 2);
    tick();

    // Randomized ops against the full-width reference model.
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      d  = $urandom;
      a  = $urandom;
      start_op(op, d, a, model(op, d, a));
      wait_done($sformatf("rand%0d", i), (int'(a[4:0]) + STEP - 1) / STEP);
      tick();
    end

    // Reset mid-shift aborts with no Done.
    start_op(2'b00, 32'h0000_FFFF, 32'd20, 32'h0);
    void'(sb_q.pop_back());
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort result", Result, 32'h0);
    check("abort busy", {31'b0, Busy}, 32'd0);
    check("abort done", {31'b0, Done}, 32'd0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (Done === 1'b1) dones++;
      tick();
    end
    check("abort no done", dones, 32'd0);
    check("scoreboard empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
